rs_decode_sequencer: RTL

//   Frame-level controller for the RS(n,k) decoder. Accepts one n-symbol frame and

---
 rtl/rs_pkg.sv | 25 ++
 rtl/rs_root_checker.sv | 53 +++++
 rtl/rs_decode_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the RS(n,k) decoder frame controller.
package rs_pkg;

  localparam int N          = 255;
  localparam int K          = 239;
  localparam int T          = 8;
  localparam int M          = 8;
  localparam int FORNEY_LAT = 14;
  localparam int BM_TMO     = 64;

  localparam int CNT_W  = $clog2(N + 1);
  localparam int TMO_W  = $clog2(BM_TMO);
  localparam int LAT_W  = $clog2(FORNEY_LAT + 1);
  localparam int DEG_W  = 4;
  localparam int ROOT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BM_WAIT,
    LAT,
    EVAL
  } seq_state_e;

endpackage

// File: rtl/rs_root_checker.sv
// Counts Chien roots over the output window and compares them with deg Lambda.
// The fail decision is combinational so it lands in the eop cycle itself.
module rs_root_checker
  import rs_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             capture,
  input  logic [DEG_W-1:0] deg_in,
  input  logic             count_en,
  input  logic             chien_root,
  input  logic             last,
  output logic             fail
);

  localparam logic [DEG_W-1:0]  T_DEG    = DEG_W'(T);
  localparam logic [ROOT_W-1:0] ROOT_MAX = '1;

  logic [DEG_W-1:0]  deg_q, deg_d;
  logic              over_q, over_d;
  logic [ROOT_W-1:0] root_cnt_q, root_cnt_d;
  logic [ROOT_W-1:0] root_cnt_next;

  // root_cnt_next includes the current beat so the final symbol is counted.
  always_comb begin
    root_cnt_next = root_cnt_q;
    if (count_en && chien_root && (root_cnt_q != ROOT_MAX)) begin
      root_cnt_next = root_cnt_q + 1'b1;
    end
    deg_d      = deg_q;
    over_d     = over_q;
    root_cnt_d = root_cnt_next;
    if (capture) begin
      deg_d      = deg_in;
      over_d     = (deg_in > T_DEG);
      root_cnt_d = '0;
    end
    fail = last & (over_q | (root_cnt_next != {1'b0, deg_q}));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      deg_q      <= '0;
      over_q     <= 1'b0;
      root_cnt_q <= '0;
    end else begin
      deg_q      <= deg_d;
      over_q     <= over_d;
      root_cnt_q <= root_cnt_d;
    end
  end

endmodule

// File: rtl/rs_decode_sequencer.sv
// Frame-level controller: load n symbols, kick Berlekamp-Massey, wait out the
// Forney latency, then run the Chien/Forney output window and judge the frame.
module rs_decode_sequencer
  import rs_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             in_ready,
  output logic             Scalc_done,
  output logic             bm_start,
  input  logic             BM_done,
  input  logic [DEG_W-1:0] bm_deg,
  input  logic             chien_root,
  output logic [7:0]       sym_idx,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             frame_fail,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SYM_PRE  = CNT_W'(N - 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BM_TMO - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FORNEY_LAT - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] sym_idx_q, sym_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             scalc_done_q, scalc_done_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic             bm_capture;
  logic             eop_fail;

  assign bm_capture = (state_q == BM_WAIT) && BM_done;

  // Handshake: a beat transfers when in_valid is high while in_ready is high;
  // beats offered while in_ready is low are dropped, never stalled or queued.
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    sym_idx_d    = sym_idx_q;
    scalc_done_d = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_sop) begin
          state_d   = LOAD;
          sym_cnt_d = CNT_W'(1);
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (in_sop) begin
            sym_cnt_d = CNT_W'(1);
          end else if (sym_cnt_q == SYM_LAST) begin
            sym_cnt_d    = '0;
            tmo_cnt_d    = '0;
            scalc_done_d = 1'b1;
            state_d      = BM_WAIT;
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      BM_WAIT: begin
        if (BM_done) begin
          state_d   = LAT;
          lat_cnt_d = LAT_W'(1);
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
          abort_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      LAT: begin
        // Leaving when the count would reach FORNEY_LAT puts out_sop exactly
        // FORNEY_LAT cycles after BM_done.
        if (lat_cnt_q == LAT_LAST) begin
          state_d   = EVAL;
          lat_cnt_d = '0;
          sym_idx_d = '0;
          out_sop_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      EVAL: begin
        if (sym_idx_q == SYM_LAST) begin
          state_d   = IDLE;
          sym_idx_d = '0;
        end else begin
          sym_idx_d = sym_idx_q + 1'b1;
          out_eop_d = (sym_idx_q == SYM_PRE);
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_d == EVAL);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      sym_idx_q    <= '0;
      in_ready_q   <= 1'b1;
      scalc_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      sym_idx_q    <= sym_idx_d;
      in_ready_q   <= in_ready_d;
      scalc_done_q <= scalc_done_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
    end
  end

  rs_root_checker u_root_checker (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .capture    (bm_capture),
    .deg_in     (bm_deg),
    .count_en   (out_valid_q),
    .chien_root (chien_root),
    .last       (out_eop_q),
    .fail       (eop_fail)
  );

  assign in_ready   = in_ready_q;
  assign Scalc_done = scalc_done_q;
  assign bm_start   = scalc_done_q;
  assign sym_idx    = sym_idx_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign frame_fail = abort_q | eop_fail;
  assign busy       = busy_q;

endmodule
